// File: rtl/hazard_scoreboard.sv
// Decode-stage register scoreboard: stalls RAW hazards on pending writebacks and sequences the post-redirect flush.
// stall/issue are combinational from ID fields, counters and FSM state; flush is registered.
module hazard_scoreboard #(
  parameter int WB_LATENCY   = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [3:0]  id_op_code,
  input  logic [3:0]  id_rd,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic        ex_mispredict,
  output logic        stall,
  output logic        issue,
  output logic        flush,
  output logic [15:0] busy_mask
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic        flush_q, flush_d;
  logic [2:0]  cnt_q [16];
  logic [2:0]  cnt_d [16];

  logic        reads_rs1, reads_rs2, writes_rd;
  logic        hazard, in_run, load;

  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    writes_rd = 1'b0;
    case (id_op_code)
      4'b1100, 4'b1101: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
        writes_rd = 1'b1;
      end
      4'b0100, 4'b0101, 4'b0111, 4'b0110: begin
        reads_rs1 = 1'b1;
        writes_rd = 1'b1;
      end
      4'b0010, 4'b0011: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 16; i++) busy_mask[i] = (cnt_q[i] != 3'd0);
  end

  assign hazard = id_valid && ((reads_rs1 && busy_mask[id_rs1]) ||
                               (reads_rs2 && busy_mask[id_rs2]));
  assign in_run = (state_q == RUN);
  assign stall  = !reset && in_run && hazard;
  assign issue  = !reset && in_run && id_valid && !hazard && !ex_mispredict;
  assign load   = issue && writes_rd;
  assign flush  = flush_q;

  // A fresh load wins over the decrement of the same register.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      if (load && (id_rd == 4'(i)))  cnt_d[i] = 3'(WB_LATENCY);
      else if (cnt_q[i] != 3'd0)     cnt_d[i] = cnt_q[i] - 3'd1;
      else                           cnt_d[i] = 3'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN: begin
        if (ex_mispredict) begin
          state_d = FLUSH;
          fcnt_d  = 3'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (fcnt_q == 3'd1) begin
          state_d = RUN;
          fcnt_d  = 3'd0;
        end else begin
          fcnt_d  = fcnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = 3'd0;
      end
    endcase
    flush_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
      flush_q <= 1'b0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      flush_q <= flush_d;
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with WB_LATENCY=3, FLUSH_CYCLES=2.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [3:0]  id_op_code = 4'd0;
  logic [3:0]  id_rd = 4'd0;
  logic [3:0]  id_rs1 = 4'd0;
  logic [3:0]  id_rs2 = 4'd0;
  logic        ex_mispredict = 1'b0;
  logic        stall, issue, flush;
  logic [15:0] busy_mask;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard #(.WB_LATENCY(3), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op_code(id_op_code),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_mispredict(ex_mispredict),
    .stall(stall), .issue(issue), .flush(flush), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic drv(input logic v, input logic [3:0] op, input logic [3:0] rd,
                     input logic [3:0] s1, input logic [3:0] s2, input logic mp);
    id_valid = v; id_op_code = op; id_rd = rd; id_rs1 = s1; id_rs2 = s2; ex_mispredict = mp;
  endtask

  // Start a new cycle: inputs change just after the rising edge, outputs are sampled at the falling edge.
  task automatic cyc(input logic v, input logic [3:0] op, input logic [3:0] rd,
                     input logic [3:0] s1, input logic [3:0] s2, input logic mp);
    @(posedge clk); #1;
    drv(v, op, rd, s1, s2, mp);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_reset;
    drv(1'b1, 4'b1100, 4'd1, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({stall, issue, flush} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctl got=%b want=000", {stall, issue, flush});
    end
    n_checks++;
    if (busy_mask !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mask got=%h want=0000", busy_mask);
    end
    reset = 1'b0;
    drv(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    idle(2);
  endtask

  task automatic test_raw;
    cyc(1'b1, 4'b1100, 4'd1, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (issue !== 1'b1) begin n_fail++; $display("FAIL raw_writer_issue got=%b want=1", issue); end
    for (int c = 1; c <= 3; c++) begin
      cyc(1'b1, 4'b1100, 4'd2, 4'd1, 4'd0, 1'b0);
      n_checks++;
      if ({stall, issue, busy_mask} !== {2'b10, 16'h0002}) begin
        n_fail++; $display("FAIL raw_stall c%0d got=%b%b %h want=10 0002", c, stall, issue, busy_mask);
      end
    end
    cyc(1'b1, 4'b1100, 4'd2, 4'd1, 4'd0, 1'b0);
    n_checks++;
    if ({stall, issue, busy_mask} !== {2'b01, 16'h0000}) begin
      n_fail++; $display("FAIL raw_issue c4 got=%b%b %h want=01 0000", stall, issue, busy_mask);
    end
    idle(4);
  endtask

  task automatic test_class_select;
    cyc(1'b1, 4'b0100, 4'd1, 4'd0, 4'd0, 1'b0);
    cyc(1'b1, 4'b0011, 4'd0, 4'd0, 4'd1, 1'b0);
    n_checks++;
    if ({stall, issue} !== 2'b10) begin n_fail++; $display("FAIL sw_rs2_stall got=%b want=10", {stall, issue}); end
    cyc(1'b1, 4'b0111, 4'd4, 4'd2, 4'd1, 1'b0);
    n_checks++;
    if ({stall, issue} !== 2'b01) begin n_fail++; $display("FAIL lw_ignores_rs2 got=%b want=01", {stall, issue}); end
    cyc(1'b1, 4'b1111, 4'd0, 4'd1, 4'd1, 1'b0);
    n_checks++;
    if ({stall, issue, busy_mask} !== {2'b01, 16'h0012}) begin
      n_fail++; $display("FAIL nop_issue got=%b%b %h want=01 0012", stall, issue, busy_mask);
    end
    cyc(1'b0, 4'b0010, 4'd0, 4'd4, 4'd4, 1'b0);
    n_checks++;
    if ({stall, issue} !== 2'b00) begin n_fail++; $display("FAIL invalid_no_stall got=%b want=00", {stall, issue}); end
    idle(4);
  endtask

  task automatic test_mispredict;
    cyc(1'b1, 4'b0100, 4'd6, 4'd0, 4'd0, 1'b1);
    n_checks++;
    if ({stall, issue, flush} !== 3'b000) begin
      n_fail++; $display("FAIL mp_cycle got=%b want=000", {stall, issue, flush});
    end
    cyc(1'b1, 4'b0100, 4'd6, 4'd0, 4'd0, 1'b1);
    n_checks++;
    if ({stall, issue, flush, busy_mask} !== {3'b001, 16'h0000}) begin
      n_fail++; $display("FAIL mp_flush1 got=%b %h want=001 0000", {stall, issue, flush}, busy_mask);
    end
    cyc(1'b1, 4'b1100, 4'd2, 4'd6, 4'd6, 1'b0);
    n_checks++;
    if ({stall, issue, flush} !== 3'b001) begin
      n_fail++; $display("FAIL mp_flush2 got=%b want=001", {stall, issue, flush});
    end
    cyc(1'b1, 4'b1100, 4'd2, 4'd6, 4'd6, 1'b0);
    n_checks++;
    if ({stall, issue, flush} !== 3'b010) begin
      n_fail++; $display("FAIL mp_resume got=%b want=010", {stall, issue, flush});
    end
    idle(4);
  endtask

  task automatic test_waw;
    cyc(1'b1, 4'b0100, 4'd5, 4'd0, 4'd0, 1'b0);
    cyc(1'b1, 4'b1100, 4'd5, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if ({stall, issue, busy_mask} !== {2'b01, 16'h0020}) begin
      n_fail++; $display("FAIL waw_second got=%b%b %h want=01 0020", stall, issue, busy_mask);
    end
    for (int c = 2; c <= 4; c++) begin
      cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
      n_checks++;
      if (busy_mask !== 16'h0020) begin
        n_fail++; $display("FAIL waw_busy c%0d got=%h want=0020", c, busy_mask);
      end
    end
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (busy_mask !== 16'h0000) begin n_fail++; $display("FAIL waw_clear c5 got=%h want=0000", busy_mask); end
    idle(2);
  endtask

  task automatic test_back_to_back;
    cyc(1'b1, 4'b0100, 4'd3, 4'd0, 4'd0, 1'b0);
    cyc(1'b1, 4'b0100, 4'd7, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    cyc(1'b1, 4'b0100, 4'd3, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if ({issue, busy_mask} !== {1'b1, 16'h0088}) begin
      n_fail++; $display("FAIL reload_cnt1 got=%b %h want=1 0088", issue, busy_mask);
    end
    cyc(1'b1, 4'b0100, 4'd9, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if ({issue, busy_mask} !== {1'b1, 16'h0088}) begin
      n_fail++; $display("FAIL reload_next got=%b %h want=1 0088", issue, busy_mask);
    end
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (busy_mask !== 16'h0208) begin n_fail++; $display("FAIL expire_r7 got=%h want=0208", busy_mask); end
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (busy_mask !== 16'h0208) begin n_fail++; $display("FAIL r3_cnt1 got=%h want=0208", busy_mask); end
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (busy_mask !== 16'h0200) begin n_fail++; $display("FAIL r3_clear got=%h want=0200", busy_mask); end
    idle(3);
  endtask

  task automatic test_reset_mid_op;
    cyc(1'b1, 4'b0100, 4'd1, 4'd0, 4'd0, 1'b0);
    cyc(1'b1, 4'b0100, 4'd5, 4'd0, 4'd0, 1'b0);
    cyc(1'b1, 4'b0000, 4'd0, 4'd0, 4'd0, 1'b1);
    cyc(1'b1, 4'b0011, 4'd0, 4'd5, 4'd1, 1'b0);
    n_checks++;
    if ({flush, busy_mask} !== {1'b1, 16'h0022}) begin
      n_fail++; $display("FAIL pre_reset got=%b %h want=1 0022", flush, busy_mask);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({stall, issue, flush, busy_mask} !== {3'b000, 16'h0000}) begin
      n_fail++; $display("FAIL async_reset got=%b %h want=000 0000", {stall, issue, flush}, busy_mask);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({stall, issue, flush} !== 3'b010) begin
      n_fail++; $display("FAIL post_reset_issue got=%b want=010", {stall, issue, flush});
    end
    idle(3);
  endtask

  initial begin
    test_reset;
    test_raw;
    test_class_select;
    test_mispredict;
    test_waw;
    test_back_to_back;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register scoreboard and issue controller for the pipelined CPU's decode stage. It tracks pending writebacks to the 16 architectural registers and stalls any decoded instruction that reads a register not yet written back. It also sequences the pipeline flush after an execute-stage branch or jump redirect. It sits between the Decoder outputs (op_code, rd, rs1, rs2) and the ID/EX pipeline register enables.

## Interface
Parameters:
- WB_LATENCY, 3: cycles from issue until the result is readable from the register file; range 1..7.
- FLUSH_CYCLES, 2: cycles `flush` is held after a redirect; range 1..7.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_op_code  in  4  decoded opcode field, inst[31:28].
- id_rd  in  4  destination register, inst[23:20].
- id_rs1  in  4  source register 1, inst[19:16].
- id_rs2  in  4  source register 2, inst[15:12].
- ex_mispredict  in  1  single-cycle pulse: execute has resolved a taken redirect.
- stall  out  1  hold PC/IF/ID; insert a bubble into EX.
- issue  out  1  the decode instruction advances to EX this cycle.
- flush  out  1  invalidate the IF/ID contents.
- busy_mask  out  16  bit r is high while register r has a pending write.

## Operation
- Opcode classes determine which registers are read and whether rd is written. Opcodes not listed below are treated as NOP: no reads, no write, and they issue normally.
  - 1100 ALU-R and 1101 CMP-R: read rs1 and rs2; write rd.
  - 0100 ALU-I, 0101 CMP-I, 0111 LW and 0110 JAL: read rs1; write rd.
  - 0010 BRANCH and 0011 SW: read rs1 and rs2; no write.
- Scoreboard: each of the 16 registers has a countdown counter of 3 bits.
  - All 16 registers are tracked; none is hardwired.
  - busy[r] = (cnt[r] != 0).
  - busy_mask is driven directly from the counters.
- Counter update each edge:
  - If the issuing instruction writes rd, cnt[rd] is loaded with WB_LATENCY. The load takes priority over the decrement.
  - Every other nonzero counter decrements by 1.
- WAW (a write to a register that is already busy): no stall; the counter reloads.
- Stall logic:
  - hazard = id_valid AND (any register read by the class is busy).
  - Fields the class does not read are ignored.
- FSM states:
  - RUN: stall = hazard; issue = id_valid AND NOT hazard AND NOT ex_mispredict. If ex_mispredict is sampled high, go to FLUSH with fcnt = FLUSH_CYCLES.
  - FLUSH: flush = 1; stall = 0; issue = 0; fcnt decrements each cycle. When fcnt reaches 1, return to RUN. ex_mispredict is ignored in FLUSH.
- Scoreboard counters keep decrementing during FLUSH. Older in-flight writes remain valid.
- An instruction in ID during the ex_mispredict cycle is wrong-path. It never issues and never loads the scoreboard.

## Timing
- Reset (asynchronous, immediate on assertion):
  - All counters = 0, so busy_mask = 0.
  - FSM = RUN, flush = 0.
  - stall and issue are forced to 0 while reset is high.
  - Reset asserted mid-stall or mid-flush aborts the operation with no residue.
- stall and issue are combinational from the inputs, the counters and the FSM state.
- flush is registered. It is high for exactly FLUSH_CYCLES cycles, starting the cycle after the ex_mispredict cycle.
- RAW latency: a reader directly behind a writer stalls WB_LATENCY cycles and issues in cycle WB_LATENCY+1 relative to the writer.
- There is no same-cycle write-to-read bypass: cnt = 1 still counts as busy.
- A nonzero counter reaches 0 after WB_LATENCY edges with no reload. Counters never wrap below 0.

## Test plan
- Reset mid-operation:
  - Stimulus: load cnt[1] and cnt[5], enter FLUSH, then assert reset asynchronously between edges.
  - Required response: busy_mask = 16'h0000, flush = 0 and stall = 0 immediately; issue resumes on the first valid instruction after release.
- RAW hazard, WB_LATENCY = 3:
  - Stimulus: ADD (1100) with rd = 1 issues in cycle 0; ADD reading rs1 = 1 is in ID in cycle 1.
  - Required response: stall = 1 in cycles 1–3, issue = 1 in cycle 4, busy_mask[1] high in cycles 1–3.
- Class-selective reads, with r1 busy:
  - SW (0011) with rs2 = 1: stall = 1.
  - LW (0111) with rs2 field = 1 and rs1 = 2 (not busy): stall = 0, issue = 1.
  - Opcode 1111 with rs1 = 1: issue = 1.
- Mispredict, FLUSH_CYCLES = 2:
  - Stimulus: ex_mispredict = 1 in cycle n with id_valid = 1.
  - Required response: issue = 0 in cycle n; flush = 1 in cycles n+1 and n+2; issue = 1 in cycle n+3; no scoreboard load from the wrong-path instruction.
- WAW reload:
  - Stimulus: a writer to rd = 5 issues in cycle 0 and a second writer to rd = 5 issues in cycle 1.
  - Required response: no stall; busy_mask[5] high in cycles 1–4 and low in cycle 5.
- Simultaneous events:
  - Stimulus: in the same cycle a new writer to rd = 3 issues while cnt[3] = 1 and cnt[7] = 1.
  - Required response: next cycle cnt[3] = 3 (busy_mask[3] = 1) and busy_mask[7] = 0.
